// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, mux select codes
// and the 4-bit FSM state encoding.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BEQ       = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles in a memory-wait state and raises a sticky
// timeout flag when the wait limit is hit.
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic mem_ready,
    output logic expired,
    output logic mem_timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    logic [CNT_W-1:0] cnt;

    // mem_ready in the limit cycle wins, so expiry needs the stall to persist
    assign expired = waiting && !mem_ready && (cnt >= LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            mem_timeout <= 1'b0;
        end else if (expired) begin
            cnt         <= '0;
            mem_timeout <= 1'b1;
        end else if (waiting && !mem_ready) begin
            if (cnt != LIMIT) cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/write-back
// and decodes datapath selects and strobes from the current state.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    state_t cur, nxt;
    logic   waiting, expired;

    assign waiting = (cur == S_FETCH) || (cur == S_MEM_READ) || (cur == S_MEM_WRITE);
    assign state   = cur;

    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .waiting    (waiting),
        .mem_ready  (mem_ready),
        .expired    (expired),
        .mem_timeout(mem_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_FETCH;
        else        cur <= nxt;
    end

    always_comb begin
        nxt         = cur;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUop       = ALU_ADD;
        PCSource    = PCSRC_ALU;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (cur)
            S_FETCH: begin
                MemRead = !expired;
                ALUSrcB = SRCB_FOUR;
                // gated by rst_n so a ready memory cannot load IR/PC while held in reset
                if (mem_ready && rst_n) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    nxt     = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
                case (opcode)
                    OP_RTYPE:     nxt = S_R_EXEC;
                    OP_LW, OP_SW: nxt = S_MEM_ADDR;
                    OP_BEQ:       nxt = S_BEQ;
                    OP_J:         nxt = S_JUMP;
                    OP_ADDI:      nxt = S_ADDI_EXEC;
                    default: begin
                        illegal_op = 1'b1;
                        nxt        = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                nxt     = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                MemRead = !expired;
                IorD    = 1'b1;
                if (mem_ready) nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite = !expired;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nxt        = S_FETCH;
                end
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = ALU_FUNCT;
                nxt     = S_R_WB;
            end
            S_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUop       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
                nxt         = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                nxt     = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
        if (expired) nxt = S_FETCH;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized and directed bench for multicycle_control, checked against a route-table
// model of instruction sequencing with a stall counter.
module tb_multicycle_control;

    localparam int LIMIT = 15;

    logic       clk = 1'b0, rst_n = 1'b1, mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg;
    logic       RegWrite, RegDst, ALUSrcA, instr_done, illegal_op, mem_timeout;
    logic [1:0] ALUSrcB, ALUop, PCSource;
    logic [3:0] state;
    logic [22:0] obs;

    int n_chk = 0, n_fail = 0;

    multicycle_control #(.WAIT_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
        .PCSource(PCSource), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    assign obs = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                  RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUop, PCSource, instr_done,
                  illegal_op, mem_timeout};

    // ---------------- reference model ----------------
    logic [16:0] ctl_tab [12];
    int  m_seq[$];
    int  m_idx, m_wait, m_est;
    bit  m_to, m_wt, m_expire;

    function automatic logic [16:0] cw(input bit pcw, pcc, iord, mrd, mwr, irw, m2r, rw, rd, asa,
                                       input logic [1:0] asb, aop, pcs, input bit done);
        return {pcw, pcc, iord, mrd, mwr, irw, m2r, rw, rd, asa, asb, aop, pcs, done};
    endfunction

    function automatic bit op_ok(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08};
    endfunction

    task automatic start_seq(input logic [5:0] op);
        case (op)
            6'h00:   m_seq = '{0, 1, 6, 7};
            6'h23:   m_seq = '{0, 1, 2, 3, 4};
            6'h2b:   m_seq = '{0, 1, 2, 5};
            6'h04:   m_seq = '{0, 1, 8};
            6'h02:   m_seq = '{0, 1, 9};
            6'h08:   m_seq = '{0, 1, 10, 11};
            default: m_seq = '{0, 1};
        endcase
    endtask

    task automatic model_reset();
        m_seq = '{0}; m_idx = 0; m_wait = 0; m_to = 0;
    endtask

    task automatic model_exp(output logic [22:0] e);
        logic [16:0] c;
        m_est    = m_seq[m_idx];
        m_wt     = (m_est == 0) || (m_est == 3) || (m_est == 5);
        m_expire = m_wt && !mem_ready && (m_wait == LIMIT);
        c = ctl_tab[m_est];
        if (m_est == 0 && mem_ready) begin c[16] = 1'b1; c[11] = 1'b1; end
        if (m_est == 5 && mem_ready) c[0] = 1'b1;
        if (m_expire) begin c[13] = 1'b0; c[12] = 1'b0; end
        e = {4'(m_est), c, (m_est == 1) && !op_ok(opcode), m_to};
    endtask

    task automatic model_adv();
        if (m_expire) begin
            m_to = 1; m_wait = 0; m_seq = '{0}; m_idx = 0;
        end else if (m_wt && !mem_ready) begin
            m_wait++;
        end else begin
            m_wait = 0;
            if (m_est == 0) begin
                start_seq(opcode); m_idx = 1;
            end else begin
                m_idx++;
                if (m_idx >= m_seq.size()) begin m_seq = '{0}; m_idx = 0; end
            end
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [22:0] e;
        e = {4'd0, ctl_tab[0], 1'b0, 1'b0};
        mem_ready = 1'b1; opcode = 6'h23;
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_async: got %h want %h", obs, e); end
        step();
        n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_held: got %h want %h", obs, e); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_instr(input string nm, input logic [5:0] op, input int stall,
                              input int exp_cyc, input int exp_done);
        logic [22:0] e;
        int cyc = 0, done = 0, st = 0;
        opcode = op;
        do begin
            mem_ready = !(m_seq[m_idx] == 3 && st < stall);
            if (!mem_ready) st++;
            #1 model_exp(e);
            n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, obs, e); end
            done += int'(instr_done);
            model_adv(); step(); cyc++;
        end while (m_idx != 0 && cyc < 64);
        n_chk++;
        if (cyc != exp_cyc) begin n_fail++; $display("FAIL %s cycles: got %0d want %0d", nm, cyc, exp_cyc); end
        n_chk++;
        if (done != exp_done) begin n_fail++; $display("FAIL %s done_pulses: got %0d want %0d", nm, done, exp_done); end
    endtask

    // stall FETCH for exactly LIMIT cycles, ready arrives in the limit cycle
    task automatic test_timeout_race();
        logic [22:0] e;
        int cyc = 0;
        opcode = 6'h00;
        do begin
            mem_ready = (cyc >= LIMIT);
            #1 model_exp(e);
            n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL race cycle %0d: got %h want %h", cyc, obs, e); end
            model_adv(); step(); cyc++;
        end while (m_idx != 0 && cyc < 64);
        n_chk++;
        if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL race_no_timeout: got %b want 0", mem_timeout); end
    endtask

    task automatic test_timeout();
        logic [22:0] e;
        opcode = 6'h00;
        for (int c = 0; c <= LIMIT + 2; c++) begin
            mem_ready = 1'b0;
            #1 model_exp(e);
            n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL timeout cycle %0d: got %h want %h", c, obs, e); end
            model_adv(); step();
        end
        n_chk++;
        if (mem_timeout !== 1'b1 || state !== 4'd0) begin
            n_fail++; $display("FAIL timeout_flag: got to=%b st=%0d want to=1 st=0", mem_timeout, state);
        end
        test_instr("after_timeout", 6'h00, 0, 4, 1);
    endtask

    task automatic test_random();
        logic [22:0] e;
        logic [5:0] ops [7];
        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h3f};
        for (int c = 0; c < 400; c++) begin
            if (m_idx == 0) opcode = ops[$urandom_range(0, 6)];
            mem_ready = ($urandom_range(0, 3) != 0);
            #1 model_exp(e);
            n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL random cycle %0d op %h: got %h want %h", c, opcode, obs, e); end
            model_adv(); step();
        end
        while (m_idx != 0) begin
            mem_ready = 1'b1;
            #1 model_exp(e);
            model_adv(); step();
        end
    endtask

    task automatic test_async_reset();
        logic [22:0] e;
        opcode = 6'h2b; mem_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1 model_exp(e);
            if (m_est == 5) break;
            n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL arst_lead cycle %0d: got %h want %h", c, obs, e); end
            model_adv(); step();
        end
        n_chk++;
        if (m_est != 5 || state !== 4'd5) begin n_fail++; $display("FAIL arst_reach_memwrite: got %0d want 5", state); end
        mem_ready = 1'b0;
        #1 model_exp(e);
        n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL arst_memwrite: got %h want %h", obs, e); end
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        e = {4'd0, ctl_tab[0], 1'b0, 1'b0};
        n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL arst_immediate: got %h want %h", obs, e); end
        step();
        rst_n = 1'b1;
        #1 model_exp(e);
        n_chk++;
        if (obs !== e || MemWrite !== 1'b0) begin
            n_fail++; $display("FAIL arst_release: got %h want %h (MemWrite=%b)", obs, e, MemWrite);
        end
        model_adv(); step();
        test_instr("sw_after_reset", 6'h2b, 0, 4, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_tab[0]  = cw(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0);
        ctl_tab[1]  = cw(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0);
        ctl_tab[2]  = cw(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0);
        ctl_tab[3]  = cw(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
        ctl_tab[4]  = cw(0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00, 1);
        ctl_tab[5]  = cw(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
        ctl_tab[6]  = cw(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0);
        ctl_tab[7]  = cw(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 1);
        ctl_tab[8]  = cw(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1);
        ctl_tab[9]  = cw(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 1);
        ctl_tab[10] = cw(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0);
        ctl_tab[11] = cw(0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 1);
        model_reset();

        test_reset();
        test_instr("rtype",   6'h00, 0, 4, 1);
        test_instr("lw_wait", 6'h23, 3, 8, 1);
        test_instr("sw",      6'h2b, 0, 4, 1);
        test_instr("beq",     6'h04, 0, 3, 1);
        test_instr("j",       6'h02, 0, 3, 1);
        test_instr("addi",    6'h08, 0, 4, 1);
        test_instr("lw",      6'h23, 0, 5, 1);
        test_instr("illegal", 6'h3f, 0, 2, 0);
        test_timeout_race();
        test_timeout();
        test_random();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
